// File: rtl/catalog_counter_ctrl_if.sv
// Bus between the interval-timer controller and the rest of the system.
// It carries three groups of signals:
//  - arm/abort requests: START, STOP, MODE, LEN
//  - 74x163-style counter control: CNT_P, CNT_T, CNT_LOAD, CNT_CLR, CNT_DATA,
//    plus the feedback RCO and Qdata
//  - status: BUSY, TICK, DONE, TICKS
// The slave modport is the controller side. The master modport is the side of
// the system and the counter.
interface catalog_counter_ctrl_if #(
  parameter int unsigned TICK_W = 8
);
  logic              START;
  logic              STOP;
  logic              MODE;
  logic [3:0]        LEN;
  logic              RCO;
  logic [3:0]        Qdata;
  logic              CNT_P;
  logic              CNT_T;
  logic              CNT_LOAD;
  logic              CNT_CLR;
  logic [3:0]        CNT_DATA;
  logic              BUSY;
  logic              TICK;
  logic              DONE;
  logic [TICK_W-1:0] TICKS;

  modport slave (
    input  START, STOP, MODE, LEN, RCO, Qdata,
    output CNT_P, CNT_T, CNT_LOAD, CNT_CLR, CNT_DATA, BUSY, TICK, DONE, TICKS
  );

  modport master (
    output START, STOP, MODE, LEN, RCO, Qdata,
    input  CNT_P, CNT_T, CNT_LOAD, CNT_CLR, CNT_DATA, BUSY, TICK, DONE, TICKS
  );
endinterface

// File: rtl/catalog_counter_ctrl.sv
// Interval-timer controller for one external 74x163-style 4-bit counter.
// It preloads the counter with 16-LEN and lets it count. On RCO it either
// reloads the counter (periodic mode) or clears it and stops (one-shot mode).
// Ports:
//  CLK  rising-edge clock
//  CLR  asynchronous active-low reset
//  bus  slave side of catalog_counter_ctrl_if
//       inputs:  START, STOP, MODE, LEN, RCO, Qdata
//       outputs: CNT_P, CNT_T, CNT_LOAD, CNT_CLR, CNT_DATA (combinational)
//                BUSY, TICK, DONE, TICKS (registered)
module catalog_counter_ctrl #(
  parameter int unsigned TICK_W = 8
) (
  input  logic                  CLK,
  input  logic                  CLR,
  catalog_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        len_q, len_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic [TICK_W-1:0] ticks_q, ticks_d;
  logic              cnt_p, cnt_t, cnt_load, cnt_clr;

  // T feeds the counter's RCO (RCO = T & Q==15), so T must not depend on RCO.
  // If it did, clearing T on a one-shot terminal count would form an
  // oscillating loop. T therefore stays high for the whole of RUN. On the
  // terminal cycle P is dropped instead, and CLR overrides counting anyway.
  assign cnt_t = (state_q == S_RUN) && !bus.STOP;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = done_q;
    ticks_d  = ticks_q;
    cnt_p    = 1'b0;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.START) begin
          state_d = S_ARM;
          len_d   = bus.LEN;
          mode_d  = bus.MODE;
        end
      end
      S_ARM: begin
        cnt_load = 1'b1;
        ticks_d  = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        cnt_p = 1'b1;
        if (bus.RCO) begin
          tick_d = 1'b1;
          if (mode_q) begin
            // Reload on the terminal cycle so the counter never wraps to 0.
            cnt_load = 1'b1;
            ticks_d  = (&ticks_q) ? ticks_q : ticks_q + 1'b1;
          end else begin
            cnt_clr = 1'b1;
            cnt_p   = 1'b0;
            done_d  = 1'b1;
            ticks_d = TICK_W'(1);
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        cnt_clr = 1'b1;
        if (bus.START) begin
          state_d = S_ARM;
          len_d   = bus.LEN;
          mode_d  = bus.MODE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // STOP overrides whatever the state wanted this cycle, including a
    // simultaneous START or RCO.
    if (bus.STOP) begin
      state_d  = S_IDLE;
      len_d    = len_q;
      mode_d   = mode_q;
      tick_d   = 1'b0;
      done_d   = 1'b0;
      ticks_d  = ticks_q;
      cnt_p    = 1'b0;
      cnt_load = 1'b0;
      cnt_clr  = 1'b1;
    end

    busy_d = (state_d == S_ARM) || (state_d == S_RUN);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      ticks_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      ticks_q <= ticks_d;
    end
  end

  assign bus.CNT_P    = cnt_p;
  assign bus.CNT_T    = cnt_t;
  assign bus.CNT_LOAD = cnt_load;
  assign bus.CNT_CLR  = cnt_clr;
  assign bus.CNT_DATA = ~len_q + 4'd1;
  assign bus.BUSY     = busy_q;
  assign bus.TICK     = tick_q;
  assign bus.DONE     = done_q;
  assign bus.TICKS    = ticks_q;

endmodule
